// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the Z80 I/O bridge: FSM state encoding,
// write-FIFO entry layout and the idle level of a filtered strobe.
package cpu_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_HOLD     = 2'd3
  } state_t;

  // Widest port index the bridge supports (NUM_PORTS up to 16).
  localparam int MAX_AW = 4;

  typedef struct packed {
    logic [MAX_AW-1:0] adr;
    logic [7:0]        data;
  } fifo_entry_t;

  // Filtered strobes are active-high internally; this is their idle level.
  localparam logic STROBE_INACTIVE = 1'b0;

endpackage

// File: rtl/cpu_io_bridge_strobe_filter.sv
// Two-flop synchroniser followed by a FILTER_LEN-sample agreement filter.
// The filtered output flips only after FILTER_LEN consecutive synchronised
// samples disagree with it, giving FILTER_LEN+2 cycles from raw to output.
module strobe_filter
  import cpu_io_pkg::*;
#(
  parameter int FILTER_LEN = 3
) (
  input  logic clk_w,
  input  logic reset_n_w,
  input  logic strobe_raw,
  output logic strobe_filt
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FILTER_LEN - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous strobe into the clk_w domain.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      sync_1 <= STROBE_INACTIVE;
      sync_2 <= STROBE_INACTIVE;
    end else begin
      sync_1 <= strobe_raw;
      sync_2 <= sync_1;
    end
  end

  // Down-counter reloads whenever the sample agrees; flip the output at terminal count.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      cnt         <= CNT_LOAD;
      strobe_filt <= STROBE_INACTIVE;
    end else if (sync_2 == strobe_filt) begin
      cnt <= CNT_LOAD;
    end else if (cnt == '0) begin
      strobe_filt <= sync_2;
      cnt         <= CNT_LOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/cpu_io_bridge.sv
// Z80 I/O port bridge: decodes a block of NUM_PORTS ports at BASE_ADDR,
// filters the bus strobes and turns each accepted cycle into a one-cycle
// req/ack handshake towards the core.
// Optional build macro CPU_IO_WRITE_FIFO_EN: posted writes through a
// FIFO_DEPTH-entry FIFO, with reads ordered behind queued writes.
//
// state       | meaning
// ST_IDLE     | no transaction; picks FIFO head (if enabled) or pending read/write
// ST_REQ      | req asserted for this single cycle; ack here is honoured
// ST_WAIT_ACK | waiting for core ack; wrt/adr/dbo frozen
// ST_HOLD     | transaction done; wait for both filtered strobes to go idle
module cpu_io_bridge
  import cpu_io_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'h98,
  parameter int          NUM_PORTS  = 4,
  parameter int          FILTER_LEN = 3,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                         clk_w,
  input  logic                         reset_n_w,
  input  logic [7:0]                   io_addr,
  input  logic                         iorq_n,
  input  logic                         rd_n,
  input  logic                         wr_n,
  input  logic [7:0]                   cd_in,
  output logic [7:0]                   cd_out,
  output logic                         cd_oe,
  output logic                         req,
  output logic                         wrt,
  output logic [$clog2(NUM_PORTS)-1:0] adr,
  output logic [7:0]                   dbo,
  input  logic                         ack,
  input  logic [7:0]                   dbi,
  output logic                         busy,
  output logic                         overflow
);

  localparam int AW = $clog2(NUM_PORTS);

  logic          hit;
  logic [AW-1:0] port_idx;
  logic          rd_f;
  logic          wr_f;
  logic          rd_q;
  logic          wr_q;
  logic          accept_rd;
  logic          accept_wr;
  logic          take_new;

  state_t        state;
  logic          pend;
  logic          pend_wr;
  logic [AW-1:0] hold_adr;
  logic [7:0]    hold_data;

  assign hit      = ~iorq_n & (io_addr[7:AW] == BASE_ADDR[7:AW]);
  assign port_idx = io_addr[AW-1:0];

  // Read data is driven straight off the raw bus strobes so it tracks bus timing.
  assign cd_oe = hit & ~rd_n & wr_n;

  strobe_filter #(.FILTER_LEN(FILTER_LEN)) u_rd_filter (
    .clk_w      (clk_w),
    .reset_n_w  (reset_n_w),
    .strobe_raw (hit & ~rd_n),
    .strobe_filt(rd_f)
  );

  strobe_filter #(.FILTER_LEN(FILTER_LEN)) u_wr_filter (
    .clk_w      (clk_w),
    .reset_n_w  (reset_n_w),
    .strobe_raw (hit & ~wr_n),
    .strobe_filt(wr_f)
  );

  // Previous filtered levels for rising-edge detection.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      rd_q <= STROBE_INACTIVE;
      wr_q <= STROBE_INACTIVE;
    end else begin
      rd_q <= rd_f;
      wr_q <= wr_f;
    end
  end

  // A rising edge counts only when the other strobe is idle; both together is a bus fault.
  assign accept_rd = rd_f & ~rd_q & ~wr_f;
  assign accept_wr = wr_f & ~wr_q & ~rd_f;

`ifdef CPU_IO_WRITE_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);

  fifo_entry_t   fifo_mem [FIFO_DEPTH];
  fifo_entry_t   fifo_head;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   fifo_count;
  logic          fifo_full;
  logic          push_ok;
  logic          pop;

  assign fifo_full = (fifo_count == (PW+1)'(FIFO_DEPTH));
  assign push_ok   = accept_wr & ~fifo_full;
  // The head stays queued until the core acks it, so a stalled drain still occupies a slot.
  assign pop       = wrt & ack & ((state == ST_REQ) || (state == ST_WAIT_ACK));
  assign fifo_head = fifo_mem[rptr];
  assign busy      = fifo_full;
  assign take_new  = accept_rd & ~pend;

  // FIFO storage needs no reset; validity comes from the pointers.
  always_ff @(posedge clk_w) begin
    if (push_ok) begin
      fifo_mem[wptr] <= {MAX_AW'(port_idx), cd_in};
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);
      if (pop)     rptr <= rptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (accept_wr && fifo_full) overflow <= 1'b1;
    end
  end
`else
  assign busy     = 1'b0;
  assign overflow = 1'b0;
  assign take_new = (accept_rd | accept_wr) & ~pend;
`endif

  // Transaction FSM with registered core-side outputs and holding registers.
  always_ff @(posedge clk_w or negedge reset_n_w) begin
    if (!reset_n_w) begin
      state     <= ST_IDLE;
      req       <= 1'b0;
      wrt       <= 1'b0;
      adr       <= '0;
      dbo       <= '0;
      cd_out    <= 8'hFF;
      pend      <= 1'b0;
      pend_wr   <= 1'b0;
      hold_adr  <= '0;
      hold_data <= '0;
    end else begin
      req <= 1'b0;
      if (take_new) begin
        pend      <= 1'b1;
        pend_wr   <= accept_wr;
        hold_adr  <= port_idx;
        hold_data <= cd_in;
      end
      case (state)
        ST_IDLE: begin
`ifdef CPU_IO_WRITE_FIFO_EN
          if (fifo_count != '0) begin
            req   <= 1'b1;
            wrt   <= 1'b1;
            adr   <= fifo_head.adr[AW-1:0];
            dbo   <= fifo_head.data;
            state <= ST_REQ;
          end else if (pend) begin
            req   <= 1'b1;
            wrt   <= pend_wr;
            adr   <= hold_adr;
            dbo   <= hold_data;
            pend  <= 1'b0;
            state <= ST_REQ;
          end else if (accept_wr) begin
            state <= ST_HOLD;
          end
`else
          if (pend) begin
            req   <= 1'b1;
            wrt   <= pend_wr;
            adr   <= hold_adr;
            dbo   <= hold_data;
            pend  <= 1'b0;
            state <= ST_REQ;
          end
`endif
        end
        ST_REQ, ST_WAIT_ACK: begin
          if (ack) begin
            if (!wrt) cd_out <= dbi;
            state <= ST_HOLD;
          end else begin
            state <= ST_WAIT_ACK;
          end
        end
        ST_HOLD: begin
          if ((rd_f == STROBE_INACTIVE) && (wr_f == STROBE_INACTIVE)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu_io_bridge.md
CPU_IO_BRIDGE -- requirements
Module: cpu_io_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h98, first decoded I/O port.
REQ-002 SHALL have parameter NUM_PORTS, default 4, decoded port count; power of 2, range 2..16.
REQ-003 SHALL have parameter FILTER_LEN, default 3, number of consecutive equal samples required to change a filtered strobe.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, write FIFO entries; power of 2.
REQ-005 SHALL have port clk_w, input, 1 bit, core clock.
REQ-006 SHALL have port reset_n_w, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port io_addr, input, 8 bits, Z80 A7..A0.
REQ-008 SHALL have ports iorq_n, rd_n and wr_n, inputs, 1 bit each, raw asynchronous bus strobes.
REQ-009 SHALL have port cd_in, input, 8 bits, CPU write data.
REQ-010 SHALL have ports cd_out, output, 8 bits, read data, and cd_oe, output, 1 bit, bus drive enable.
REQ-011 SHALL have ports req, output, 1 bit, one-cycle core request; wrt, output, 1 bit; adr, output, AW=$clog2(NUM_PORTS) bits; dbo, output, 8 bits.
REQ-012 SHALL have ports ack, input, 1 bit, core acknowledge, and dbi, input, 8 bits, core read data.
REQ-013 SHALL have ports busy, output, 1 bit, write FIFO full, and overflow, output, 1 bit, sticky write drop flag.

Function
REQ-014 hit SHALL be ~iorq_n & (io_addr[7:AW] == BASE_ADDR[7:AW]); port index = io_addr[AW-1:0].
REQ-015 Filtered rd and wr strobes: hit&~rd_n / hit&~wr_n -> 2-FF synchroniser -> filter; output changes only after FILTER_LEN identical synchronised samples; total latency FILTER_LEN+2 cycles.
REQ-016 A strobe SHALL be accepted on the filtered inactive->active edge; both filtered strobes active together SHALL be ignored, with no req issued.
REQ-017 cd_in and the port index SHALL be sampled into holding registers in the same cycle as acceptance.
REQ-018 FSM: IDLE -> REQ (req=1 for exactly one cycle) -> WAIT_ACK -> HOLD -> IDLE.
REQ-019 FSM transitions: WAIT_ACK exits to HOLD on ack; HOLD exits to IDLE once both filtered strobes are inactive.
REQ-020 On ack for a read, dbi SHALL be latched into cd_out; cd_out SHALL hold that value until the next read ack.
REQ-021 An ack arriving in the REQ cycle itself SHALL be honoured, skipping WAIT_ACK.
REQ-022 cd_oe SHALL be a combinational function of the raw strobes: hit & ~rd_n & wr_n (bus timing); cd_oe SHALL never be registered.
REQ-023 req SHALL never be asserted again before the ack of the previous request.
REQ-024 wrt, adr and dbo SHALL stay stable from req until ack.

Reset
REQ-025 Reset SHALL be asynchronous; all state SHALL be valid on the first clock edge after deassertion.
REQ-026 Reset values: req=0, wrt=0, adr=0, dbo=0, cd_out=8'hFF, busy=0, overflow=0, FSM=IDLE, FIFO empty, filters=inactive.
REQ-027 Reset mid-transaction SHALL abandon the transaction; a late ack after reset SHALL be ignored in IDLE.

Configuration
REQ-028 Macro CPU_IO_WRITE_FIFO_EN defined: an accepted write SHALL push {adr,data} into the FIFO and go to HOLD without a core request.
REQ-029 With CPU_IO_WRITE_FIFO_EN, the drain SHALL issue the FIFO head as req/wrt=1 whenever the FSM is IDLE and the FIFO is non-empty.
REQ-030 With CPU_IO_WRITE_FIFO_EN, an accepted read SHALL wait until the FIFO has drained (ordering).
REQ-031 With CPU_IO_WRITE_FIFO_EN, busy=1 when the FIFO is full; a push when full SHALL be dropped and SHALL set overflow, cleared only by reset.
REQ-032 Macro undefined: writes SHALL follow the REQ-018 path directly; busy and overflow SHALL be tied 0.

Structure
REQ-033 Package cpu_io_pkg SHALL hold the FSM state enum, the FIFO entry typedef {adr,data} and the inactive-strobe constant.
REQ-034 Sub-module strobe_filter (synchroniser plus FILTER_LEN filter, parametrised) SHALL be instantiated once per strobe.

Verification
REQ-035 Write port 0x99 data 0x5A, ack after 3 cycles -> one req pulse, wrt=1, adr=1, dbo=0x5A.
REQ-036 Read port 0x98, dbi=0xC3 with ack -> cd_out=0xC3, cd_oe high only while raw rd_n low.
REQ-037 Glitch on wr_n, 2 cycles low with FILTER_LEN=3 -> no req; io_addr=0x9C -> no req.
REQ-038 FIFO_EN, ack held low, 5 writes with FIFO_DEPTH=4 -> busy=1 after 4, overflow=1; 4 entries drained in order once ack resumes.
REQ-039 FIFO_EN, 2 queued writes then read -> read req follows the second write ack.
REQ-040 reset_n_w pulsed in WAIT_ACK -> all outputs at reset values, subsequent ack ignored.
